// File: rtl/i2c_pkg.sv
// ============================================================================
// Module      : i2c_pkg
// Description : Shared constants for the I2C target front-end: FSM state
//               encodings, default target address and PID gain register map.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package i2c_pkg;

    typedef logic [3:0] state_t;

    localparam state_t C_ST_IDLE     = 4'd0;
    localparam state_t C_ST_DEV_ADDR = 4'd1;
    localparam state_t C_ST_ACK_ADDR = 4'd2;
    localparam state_t C_ST_REG_PTR  = 4'd3;
    localparam state_t C_ST_ACK_PTR  = 4'd4;
    localparam state_t C_ST_WR_DATA  = 4'd5;
    localparam state_t C_ST_ACK_DATA = 4'd6;
    localparam state_t C_ST_RD_DATA  = 4'd7;
    localparam state_t C_ST_RD_ACK   = 4'd8;
    localparam state_t C_ST_IGNORE   = 4'd9;

    localparam logic [6:0] C_DEV_ADDR_DEFAULT = 7'h2A;

    localparam logic [7:0] C_REG_KP = 8'h00;
    localparam logic [7:0] C_REG_KI = 8'h01;
    localparam logic [7:0] C_REG_KD = 8'h02;

endpackage

`default_nettype wire

// File: rtl/i2c_target_frontend_if.sv
// ============================================================================
// Module      : i2c_target_frontend_if
// Description : Register-file access bus between the I2C front-end (master)
//               and the PID gain register block (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface i2c_target_frontend_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 6
) ();

    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] update_value;
    logic              wr_stb;
    logic [DATA_W-1:0] rd_value;

    modport master (
        output reg_addr,
        output update_value,
        output wr_stb,
        input  rd_value
    );

    modport slave (
        input  reg_addr,
        input  update_value,
        input  wr_stb,
        output rd_value
    );

endinterface

`default_nettype wire

// File: rtl/i2c_sync_edge.sv
// ============================================================================
// Module      : i2c_sync_edge
// Description : SCL/SDA synchroniser with SCL edge and START/STOP detection.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_scl,
    input  wire logic i_sda,
    output logic      o_sda,
    output logic      o_scl_rise,
    output logic      o_scl_fall,
    output logic      o_start,
    output logic      o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl;
    logic                   w_sda;

    // Reset to the idle-bus level so no spurious edge appears on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];

    assign o_sda      = w_sda;
    assign o_scl_rise =  w_scl & ~r_scl_prev;
    assign o_scl_fall = ~w_scl &  r_scl_prev;
    assign o_start    = w_scl & r_scl_prev &  r_sda_prev & ~w_sda;
    assign o_stop     = w_scl & r_scl_prev & ~r_sda_prev &  w_sda;

endmodule

`default_nettype wire

// File: rtl/i2c_target_frontend.sv
// ============================================================================
// Module      : i2c_target_frontend
// Description : I2C target decoding bus transfers into PID gain register
//               accesses. Define I2C_AUTO_INC_EN for pointer auto-increment.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_target_frontend
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = C_DEV_ADDR_DEFAULT,
    parameter int         ADDR_W      = 8,
    parameter int         DATA_W      = 6,
    parameter int         SYNC_STAGES = 2
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              scl_i,
    input  wire logic              sda_i,
    output logic                   sda_oe,
    i2c_target_frontend_if.master  rf,
    output logic                   busy
);

    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    i2c_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_scl      (scl_i),
        .i_sda      (sda_i),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    state_t            r_state;
    logic [3:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_rw;
    logic              r_rd_ack;
    logic              r_sda_oe;
    logic              r_busy;
    logic              r_wr_stb;
    logic [ADDR_W-1:0] r_reg_addr;
    logic [DATA_W-1:0] r_update_value;

    logic              w_rx_state;
    logic              w_byte_done;
    logic [7:0]        w_rd_byte;

    assign w_rx_state  = (r_state == C_ST_DEV_ADDR) || (r_state == C_ST_REG_PTR) ||
                         (r_state == C_ST_WR_DATA);
    assign w_byte_done = w_scl_fall && (r_bit_cnt == 4'd8);
    assign w_rd_byte   = 8'(rf.rd_value);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= C_ST_IDLE;
            r_bit_cnt      <= 4'd0;
            r_shift        <= 8'd0;
            r_rw           <= 1'b0;
            r_rd_ack       <= 1'b0;
            r_sda_oe       <= 1'b0;
            r_busy         <= 1'b0;
            r_wr_stb       <= 1'b0;
            r_reg_addr     <= '0;
            r_update_value <= '0;
        end else begin
            r_wr_stb <= 1'b0;
`ifdef I2C_AUTO_INC_EN
            if (r_wr_stb) begin
                r_reg_addr <= r_reg_addr + ADDR_W'(1);
            end
`endif
            if (w_start) begin
                r_state   <= C_ST_DEV_ADDR;
                r_bit_cnt <= 4'd0;
                r_busy    <= 1'b1;
                r_sda_oe  <= 1'b0;
            end else if (w_stop) begin
                r_state   <= C_ST_IDLE;
                r_bit_cnt <= 4'd0;
                r_busy    <= 1'b0;
                r_sda_oe  <= 1'b0;
            end else begin
                if (w_rx_state && w_scl_rise) begin
                    r_shift   <= {r_shift[6:0], w_sda};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end

                case (r_state)
                    C_ST_DEV_ADDR: begin
                        if (w_byte_done) begin
                            r_bit_cnt <= 4'd0;
                            if (r_shift[7:1] == DEV_ADDR) begin
                                r_rw     <= r_shift[0];
                                r_sda_oe <= 1'b1;
                                r_state  <= C_ST_ACK_ADDR;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= C_ST_IGNORE;
                            end
                        end
                    end

                    C_ST_ACK_ADDR: begin
                        if (w_scl_fall) begin
                            if (r_rw) begin
                                r_shift  <= w_rd_byte;
                                r_sda_oe <= ~w_rd_byte[7];
                                r_state  <= C_ST_RD_DATA;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= C_ST_REG_PTR;
                            end
                        end
                    end

                    C_ST_REG_PTR: begin
                        if (w_byte_done) begin
                            r_bit_cnt  <= 4'd0;
                            r_reg_addr <= ADDR_W'(r_shift);
                            r_sda_oe   <= 1'b1;
                            r_state    <= C_ST_ACK_PTR;
                        end
                    end

                    C_ST_ACK_PTR, C_ST_ACK_DATA: begin
                        if (w_scl_fall) begin
                            r_sda_oe <= 1'b0;
                            r_state  <= C_ST_WR_DATA;
                        end
                    end

                    C_ST_WR_DATA: begin
                        // Strobe and ACK assert on the same clk.
                        if (w_byte_done) begin
                            r_bit_cnt      <= 4'd0;
                            r_update_value <= DATA_W'(r_shift);
                            r_wr_stb       <= 1'b1;
                            r_sda_oe       <= 1'b1;
                            r_state        <= C_ST_ACK_DATA;
                        end
                    end

                    C_ST_RD_DATA: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_bit_cnt <= 4'd0;
                                r_sda_oe  <= 1'b0;
                                r_rd_ack  <= 1'b0;
                                r_state   <= C_ST_RD_ACK;
                            end else begin
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_sda_oe <= ~r_shift[6];
                            end
                        end
                    end

                    C_ST_RD_ACK: begin
                        // Pointer moves on the ACK rise so rd_value settles before the reload fall.
                        if (w_scl_rise) begin
                            if (!w_sda) begin
                                r_rd_ack <= 1'b1;
`ifdef I2C_AUTO_INC_EN
                                r_reg_addr <= r_reg_addr + ADDR_W'(1);
`endif
                            end else begin
                                r_state <= C_ST_IGNORE;
                            end
                        end else if (w_scl_fall && r_rd_ack) begin
                            r_rd_ack <= 1'b0;
                            r_shift  <= w_rd_byte;
                            r_sda_oe <= ~w_rd_byte[7];
                            r_state  <= C_ST_RD_DATA;
                        end
                    end

                    C_ST_IGNORE: begin
                        r_sda_oe <= 1'b0;
                    end

                    default: begin
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe          = r_sda_oe;
    assign busy            = r_busy;
    assign rf.reg_addr     = r_reg_addr;
    assign rf.update_value = r_update_value;
    assign rf.wr_stb       = r_wr_stb;

endmodule

`default_nettype wire

// File: doc/i2c_target_frontend.md
Name: i2c_target_frontend

Overview:
- I2C target (slave) front-end that decodes the serial bus into register-file accesses for the PID gain registers (K_p, K_i, K_d).
- Sits directly upstream of the gain register block. It drives the register pointer, write data and write strobe, and serialises the register read value back onto SDA.
- SCL and SDA are oversampled by the system clock. SDA is driven open-drain through an output enable.

Parameters:
- DEV_ADDR, 7'h2A, 7-bit I2C target address.
- ADDR_W, 8, register pointer width.
- DATA_W, 6, register data width. Bus bytes are 8 bits; only the low DATA_W bits are used.
- SYNC_STAGES, 2, synchroniser depth for SCL/SDA; must be >= 2.

Ports:
- clk  in  1  system clock; must be at least 8x the SCL rate.
- rst_n  in  1  asynchronous active-low reset.
- scl_i  in  1  raw SCL pin.
- sda_i  in  1  raw SDA pin.
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- reg_addr  out  ADDR_W  register pointer.
- update_value  out  DATA_W  write data.
- wr_stb  out  1  one-clk write strobe.
- rd_value  in  DATA_W  read data of the register at reg_addr; must be stable while reg_addr is stable.
- busy  out  1  high from START until STOP.

Behaviour:
- Reset (async, rst_n low): sda_oe=0, wr_stb=0, busy=0, reg_addr=0, update_value=0, state=IDLE. An assertion mid-transfer releases SDA immediately. After reset the block ignores the bus until the next START.
- Synchronise SCL/SDA through SYNC_STAGES flops. Rise/fall detection is on the synchronised signals.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both are recognised in any state and take priority over bit sampling.
  - START (including repeated START) -> DEV_ADDR, bit count 0, busy=1.
  - STOP -> IDLE, sda_oe=0, busy=0.
- Bit timing:
  - Sample SDA on the SCL rising edge.
  - Change sda_oe only on the SCL falling edge, one clk after it is detected.
- States:
  - IDLE: wait for START.
  - DEV_ADDR: shift in 8 bits (7-bit address + R/W). On the 8th SCL fall, if the address matches DEV_ADDR, go to ACK_ADDR with sda_oe=1. Otherwise go to IGNORE with sda_oe=0.
  - ACK_ADDR: on the next SCL fall, release SDA.
    - R/W=0 -> REG_PTR.
    - R/W=1 -> RD_DATA, loading the shift register with {zero pad, rd_value} and driving the MSB.
  - REG_PTR: shift in 8 bits. On the 8th fall, load reg_addr and ACK.
  - ACK_PTR: on the next fall, release SDA -> WR_DATA.
  - WR_DATA: shift in 8 bits. On the 8th fall:
    - update_value <= low DATA_W bits (upper bits discarded).
    - Pulse wr_stb for exactly one clk, coincident with ACK assertion.
    - Go to ACK_DATA.
  - ACK_DATA: on the next fall, release SDA -> WR_DATA. Further bytes rewrite the same pointer.
  - RD_DATA: drive sda_oe = ~bit, MSB first, on each SCL fall. After the 8th bit, release SDA -> RD_ACK.
  - RD_ACK: sample the controller's ACK on SCL rise.
    - ACK (0): reload from rd_value -> RD_DATA.
    - NACK (1): -> IGNORE.
  - IGNORE: sda_oe=0. Wait for STOP or START.
- reg_addr and update_value hold their values until the next load. wr_stb is never asserted in a read transaction.
- A STOP or START before the 8th bit of a write byte aborts that byte: no wr_stb, and update_value is unchanged.
- A pointer-only write (address, pointer, STOP) updates reg_addr without asserting wr_stb.

Optional Feature:
- Macro: I2C_AUTO_INC_EN.
- Defined: reg_addr increments by 1, wrapping 8'hFF->8'h00, one clk after each wr_stb. It also increments after each read byte the controller ACKs, before rd_value is reloaded. This supports burst access to K_p/K_i/K_d.
- Undefined: reg_addr changes only in REG_PTR.

Decomposition:
- Package i2c_pkg:
  - State enum (IDLE, DEV_ADDR, ACK_ADDR, REG_PTR, ACK_PTR, WR_DATA, ACK_DATA, RD_DATA, RD_ACK, IGNORE).
  - Default DEV_ADDR constant.
  - Gain register address constants 8'h00/8'h01/8'h02.
- Sub-module i2c_sync_edge: SYNC_STAGES synchroniser plus rise/fall/start/stop detection for SCL and SDA. The top level holds the FSM, shift register and bit counter.

Test Plan:
- Write 0x54 (0x2A,W), 0x01, 0x15, STOP -> ACK on all three bytes; a single wr_stb with reg_addr=0x01, update_value=0x15; busy falls at STOP.
- Write 0x54, 0x02, repeated START, 0x55, controller NACK, STOP with rd_value=0x2B -> SDA byte 0x2B; sda_oe released after the 8th bit; no wr_stb.
- Address 0x56 (0x2B,W), 0xFF -> no ACK, sda_oe stays 0 throughout, no wr_stb, reg_addr unchanged.
- Write 0x54, 0x00, then STOP after 4 data bits -> no wr_stb, update_value unchanged, state IDLE.
- rst_n low during the ACK_ADDR ACK -> sda_oe=0 within the same cycle; after release, no ACK until a new START.
- I2C_AUTO_INC_EN: write 0x54, 0x00, 0x11, 0x22, 0x33 -> wr_stb at reg_addr 0x00/0x01/0x02 with values 0x11/0x22/0x33; reg_addr ends at 0x03.
